// File: rtl/move_event_queue.sv
// rtl/move_event_queue.sv - direction pulse encoder feeding a small FWFT move FIFO
module move_event_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_up,
  input  logic             pulse_down,
  input  logic             pulse_left,
  input  logic             pulse_right,
  output logic             ev_valid,
  output logic [1:0]       ev_dir,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             collision,
  input  logic             clr_flags
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             req;
  logic             multi;
  logic             full;
  logic             pop;
  logic             push;
  logic [1:0]       code;
  logic [2:0]       n_pulses;

  always_comb begin
    req      = pulse_up | pulse_down | pulse_left | pulse_right;
    n_pulses = 3'(pulse_up) + 3'(pulse_down) + 3'(pulse_left) + 3'(pulse_right);
    multi    = (n_pulses >= 3'd2);
    if (pulse_up)        code = 2'd0;
    else if (pulse_down) code = 2'd1;
    else if (pulse_left) code = 2'd2;
    else                 code = 2'd3;
  end

  assign full     = (count == CNT_W'(DEPTH));
  assign ev_valid = (count != '0);
  assign pop      = ev_valid & ev_ready;
  // When full, the pop frees the slot at wr_ptr (== rd_ptr) in the same edge.
  assign push     = req & (~full | pop);
  assign ev_dir   = ev_valid ? mem[rd_ptr] : 2'd0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      collision <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A set condition in the same cycle as clr_flags keeps the flag set.
      if (req & full & ~pop) overflow <= 1'b1;
      else if (clr_flags)    overflow <= 1'b0;
      if (multi)             collision <= 1'b1;
      else if (clr_flags)    collision <= 1'b0;
    end
  end

endmodule

// File: tb/tb_move_event_queue.sv
// tb/tb_move_event_queue.sv - randomized bench with queue-based reference model
module tb_move_event_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pulse_up, pulse_down, pulse_left, pulse_right;
  logic             ev_valid;
  logic [1:0]       ev_dir;
  logic             ev_ready;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             collision;
  logic             clr_flags;

  move_event_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pulse_up(pulse_up), .pulse_down(pulse_down),
    .pulse_left(pulse_left), .pulse_right(pulse_right),
    .ev_valid(ev_valid), .ev_dir(ev_dir), .ev_ready(ev_ready),
    .count(count), .overflow(overflow), .collision(collision),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] mq [$];
  bit         m_ovf = 0;
  bit         m_col = 0;
  int         popped_dut;
  int         seq_out [4];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("ev_valid", int'(ev_valid), (mq.size() != 0) ? 1 : 0);
    check("ev_dir", int'(ev_dir), (mq.size() != 0) ? int'(mq[0]) : 0);
    check("count", int'(count), mq.size());
    check("overflow", int'(overflow), int'(m_ovf));
    check("collision", int'(collision), int'(m_col));
  endtask

  // Applies one cycle of inputs, advances the model by the rules, compares at the next negedge.
  task automatic step(input bit u, input bit d, input bit l, input bit r,
                      input bit rdy, input bit clr);
    int         sz;
    bit         pop, req;
    int         n;
    logic [1:0] c;
    pulse_up = u; pulse_down = d; pulse_left = l; pulse_right = r;
    ev_ready = rdy; clr_flags = clr;
    sz  = mq.size();
    pop = (sz != 0) && rdy;
    req = u | d | l | r;
    n   = int'(u) + int'(d) + int'(l) + int'(r);
    c   = u ? 2'd0 : d ? 2'd1 : l ? 2'd2 : 2'd3;
    popped_dut = pop ? int'(ev_dir) : -1;
    if (pop) void'(mq.pop_front());
    if (req && (sz < DEPTH || pop)) mq.push_back(c);
    if (req && sz == DEPTH && !pop) m_ovf = 1;
    else if (clr)                   m_ovf = 0;
    if (n >= 2)   m_col = 1;
    else if (clr) m_col = 0;
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, rdy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    pulse_up = 0; pulse_down = 0; pulse_left = 0; pulse_right = 0;
    ev_ready = 0; clr_flags = 0;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(ev_valid), 0);
    check("rst_dir", int'(ev_dir), 0);
    check("rst_count", int'(count), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_col", int'(collision), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single left pulse held at the head until accepted
    repeat (4) idle(0);
    step(0, 0, 1, 0, 0, 0);
    check("t1_dir", int'(ev_dir), 2);
    check("t1_count", int'(count), 1);
    repeat (3) idle(0);
    idle(1);
    check("t1_empty", int'(ev_valid), 0);

    // Fill in order up,right,down,left then drain back to back
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("t2_count", int'(count), 4);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      seq_out[i] = popped_dut;
    end
    check("t2_out0", seq_out[0], 0);
    check("t2_out1", seq_out[1], 3);
    check("t2_out2", seq_out[2], 1);
    check("t2_out3", seq_out[3], 2);
    check("t2_valid", int'(ev_valid), 0);
    check("t2_count0", int'(count), 0);

    // Overflow on full
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("t3_ovf", int'(overflow), 1);
    check("t3_count", int'(count), 4);
    check("t3_head", int'(ev_dir), 1);
    idle(0);
    step(0, 0, 0, 0, 0, 1);
    check("t3_clr", int'(overflow), 0);

    // Push while full with a simultaneous pop
    step(0, 0, 0, 1, 1, 0);
    check("t4_count", int'(count), 4);
    check("t4_ovf", int'(overflow), 0);
    for (int i = 0; i < 4; i++) idle(1);
    check("t4_last", popped_dut, 3);

    // Collision, clear, and set-wins-over-clear
    step(0, 1, 0, 1, 0, 0);
    check("t5_col", int'(collision), 1);
    check("t5_count", int'(count), 1);
    check("t5_dir", int'(ev_dir), 1);
    step(0, 0, 0, 0, 0, 1);
    check("t5_clr", int'(collision), 0);
    step(1, 1, 0, 0, 0, 1);
    check("t5_setwins", int'(collision), 1);
    repeat (3) idle(1);

    // Asynchronous reset with entries queued
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    pulse_up = 0; pulse_down = 0; pulse_left = 0; pulse_right = 0;
    ev_ready = 1; clr_flags = 0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", int'(ev_valid), 0);
    check("t6_count", int'(count), 0);
    check("t6_col", int'(collision), 0);
    mq.delete();
    m_ovf = 0;
    m_col = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) idle(1);
    step(0, 1, 0, 0, 0, 0);
    check("t6_fresh", int'(ev_dir), 1);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
